// File: rtl/snoop_loader_if.sv
// Image-stream and snoop-write bundle between snoop_loader (master) and its environment (slave).
`timescale 1ns/1ps
interface snoop_loader_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] snoopa;
    logic [DW-1:0] snoopd;
    logic          snoopw;
    logic          snoopp;
    logic          snoopm;

    modport master (
        input  in_data, in_valid,
        output in_ready, snoopa, snoopd, snoopw, snoopp, snoopm
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, snoopa, snoopd, snoopw, snoopp, snoopm
    );
endinterface

// File: rtl/snoop_loader.sv
// Streams an image into core memory over the snoop port, then releases core reset.
// Define SNOOP_LOADER_CSUM_EN to require a trailing checksum word before release.
//
// state   | meaning
// IDLE    | waiting for start; core held in reset until first successful load
// LOAD    | accepting image words, one snoop write per non-zero word
// CHECK   | (CSUM_EN only) accepting the expected-sum word
// RELEASE | holding core_reset for RELEASE_CYC cycles, then done
`timescale 1ns/1ps
module snoop_loader #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int RELEASE_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    snoop_loader_if.master bus,
    output logic          core_reset,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW:0]   count
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_RELEASE = 2'd2
`ifdef SNOOP_LOADER_CSUM_EN
        , S_CHECK = 2'd3
`endif
    } state_t;

    localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};
    localparam logic [3:0]  REL_LOAD = 4'(RELEASE_CYC - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] snoopa_q, snoopa_d;
    logic [DW-1:0] snoopd_q, snoopd_d;
    logic          snoopw_q, snoopw_d;
    logic          core_reset_q, core_reset_d;
    logic          done_q, done_d;
    logic [3:0]    rel_cnt_q, rel_cnt_d;
    logic          in_ready_w;
    logic          last_word;
`ifdef SNOOP_LOADER_CSUM_EN
    logic [DW-1:0] sum_q, sum_d;
    logic          error_q, error_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            count_q      <= '0;
            snoopa_q     <= '0;
            snoopd_q     <= '0;
            snoopw_q     <= 1'b0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            rel_cnt_q    <= '0;
`ifdef SNOOP_LOADER_CSUM_EN
            sum_q        <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            count_q      <= count_d;
            snoopa_q     <= snoopa_d;
            snoopd_q     <= snoopd_d;
            snoopw_q     <= snoopw_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            rel_cnt_q    <= rel_cnt_d;
`ifdef SNOOP_LOADER_CSUM_EN
            sum_q        <= sum_d;
            error_q      <= error_d;
`endif
        end
    end

`ifdef SNOOP_LOADER_CSUM_EN
    assign in_ready_w = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
    assign in_ready_w = (state_q == S_LOAD);
`endif
    assign last_word = (state_q == S_LOAD) && bus.in_valid && ((count_q + ONE) == len_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = (len == '0) ? S_RELEASE : S_LOAD;
`ifdef SNOOP_LOADER_CSUM_EN
            S_LOAD:    if (last_word) state_d = S_CHECK;
            S_CHECK:   if (bus.in_valid) state_d = (bus.in_data == sum_q) ? S_RELEASE : S_IDLE;
`else
            S_LOAD:    if (last_word) state_d = S_RELEASE;
`endif
            S_RELEASE: if (rel_cnt_q == '0) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        base_d       = base_q;
        len_d        = len_q;
        count_d      = count_q;
        snoopa_d     = snoopa_q;
        snoopd_d     = snoopd_q;
        snoopw_d     = 1'b0;
        core_reset_d = core_reset_q;
        done_d       = 1'b0;
        rel_cnt_d    = rel_cnt_q;
`ifdef SNOOP_LOADER_CSUM_EN
        sum_d        = sum_q;
        error_d      = error_q;
`endif
        if (state_q == S_IDLE && start) begin
            base_d       = base;
            len_d        = len;
            count_d      = '0;
            core_reset_d = 1'b1;
`ifdef SNOOP_LOADER_CSUM_EN
            sum_d        = '0;
            error_d      = 1'b0;
`endif
        end
        // zero words advance the address but suppress the strobe
        if (state_q == S_LOAD && bus.in_valid) begin
            count_d  = count_q + ONE;
            snoopa_d = base_q + count_q[AW-1:0];
            snoopd_d = bus.in_data;
            snoopw_d = |bus.in_data;
`ifdef SNOOP_LOADER_CSUM_EN
            sum_d    = sum_q + bus.in_data;
`endif
        end
`ifdef SNOOP_LOADER_CSUM_EN
        if (state_q == S_CHECK && bus.in_valid && bus.in_data != sum_q) error_d = 1'b1;
`endif
        if (state_d == S_RELEASE && state_q != S_RELEASE) begin
            rel_cnt_d = REL_LOAD;
        end else if (state_q == S_RELEASE) begin
            if (rel_cnt_q == '0) begin
                done_d       = 1'b1;
                core_reset_d = 1'b0;
            end else begin
                rel_cnt_d = rel_cnt_q - 4'd1;
            end
        end
    end

    assign bus.in_ready = in_ready_w;
    assign bus.snoopa   = snoopa_q;
    assign bus.snoopd   = snoopd_q;
    assign bus.snoopw   = snoopw_q;
    assign bus.snoopp   = in_ready_w || snoopw_q;
    assign bus.snoopm   = 1'b0;
    assign core_reset   = core_reset_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign count        = count_q;
`ifdef SNOOP_LOADER_CSUM_EN
    assign error        = error_q;
`else
    assign error        = 1'b0;
`endif
endmodule

// File: tb/tb_snoop_loader.sv
// Directed bench for snoop_loader: strobe log from a monitor, immediate-assert checks.
`timescale 1ns/1ps
module tb_snoop_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] base = '0;
    logic [8:0] len = '0;
    logic       core_reset, busy, done, error;
    logic [8:0] count;

    snoop_loader_if #(.AW(8), .DW(8)) bus ();

    snoop_loader #(.AW(8), .DW(8), .RELEASE_CYC(2)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
        .bus(bus), .core_reset(core_reset), .busy(busy), .done(done),
        .error(error), .count(count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] str_a[$];
    logic [7:0] str_d[$];
    int         str_c[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         cr_fall_cyc = 0;
    int         pp_bad = 0;
    logic       prev_cr = 1'b1;
    logic [7:0] wbuf[0:15];

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (bus.snoopw) begin
            str_a.push_back(bus.snoopa);
            str_d.push_back(bus.snoopd);
            str_c.push_back(cyc);
            if (!bus.snoopp) pp_bad = pp_bad + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (prev_cr && !core_reset) cr_fall_cyc = cyc;
        prev_cr = core_reset;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [7:0] b, input logic [8:0] l, output int s);
        @(negedge clk);
        s = cyc;
        start = 1'b1; base = b; len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit tog);
        int   idx = 0;
        int   k = 0;
        logic v, r;
        while (idx < n && k < 200) begin
            v = tog ? ((k % 2) == 0) : 1'b1;
            bus.in_valid = v;
            bus.in_data  = wbuf[idx];
            r = bus.in_ready;
            @(negedge clk);
            if (v && r) idx++;
            k++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        chk("feed_words", idx, n);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 40 && done_cnt == d0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("done_pulses", done_cnt - d0, 1);
    endtask

    task automatic load_t1_words();
        wbuf[0] = 8'h98; wbuf[1] = 8'h0C; wbuf[2]  = 8'h14; wbuf[3]  = 8'h03;
        wbuf[4] = 8'h92; wbuf[5] = 8'hE8; wbuf[6]  = 8'h0C; wbuf[7]  = 8'h18;
        wbuf[8] = 8'h82; wbuf[9] = 8'h92; wbuf[10] = 8'h92; wbuf[11] = 8'h82;
        wbuf[12] = 8'h60;
    endtask

    initial begin
        int s, b, d0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_snoopw", bus.snoopw, 0);
        chk("rst_snoopp", bus.snoopp, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_core_reset", core_reset, 1);

`ifndef SNOOP_LOADER_CSUM_EN
        // 13-word image, in_valid always high
        load_t1_words();
        b = str_a.size(); d0 = done_cnt;
        start_load(8'h00, 9'd13, s);
        chk("t1_busy", busy, 1);
        chk("t1_snoopp_load", bus.snoopp, 1);
        feed(13, 1'b0);
        wait_done(d0);
        chk("t1_nstrobes", str_a.size() - b, 13);
        for (int i = 0; i < 13; i++) begin
            chk("t1_addr", str_a[b+i], i);
            chk("t1_data", str_d[b+i], wbuf[i]);
        end
        chk("t1_cr_delay", cr_fall_cyc - str_c[b+12], 2);
        chk("t1_core_reset", core_reset, 0);
        chk("t1_count", count, 13);
        chk("t1_busy_end", busy, 0);
        chk("t1_snoopp_end", bus.snoopp, 0);

        // wrap-around with zero-skip
        wbuf[0] = 8'h11; wbuf[1] = 8'h00; wbuf[2] = 8'h22; wbuf[3] = 8'h33;
        b = str_a.size(); d0 = done_cnt;
        start_load(8'hFE, 9'd4, s);
        feed(4, 1'b0);
        wait_done(d0);
        chk("t2_nstrobes", str_a.size() - b, 3);
        chk("t2_addr0", str_a[b], 8'hFE);
        chk("t2_data0", str_d[b], 8'h11);
        chk("t2_addr1", str_a[b+1], 8'h00);
        chk("t2_data1", str_d[b+1], 8'h22);
        chk("t2_addr2", str_a[b+2], 8'h01);
        chk("t2_data2", str_d[b+2], 8'h33);
        chk("t2_count", count, 4);

        // stalled stream
        load_t1_words();
        b = str_a.size(); d0 = done_cnt;
        start_load(8'h00, 9'd13, s);
        feed(13, 1'b1);
        wait_done(d0);
        chk("t3_nstrobes", str_a.size() - b, 13);
        for (int i = 0; i < 13; i++) begin
            chk("t3_addr", str_a[b+i], i);
            chk("t3_data", str_d[b+i], wbuf[i]);
        end
        chk("t3_stall_gap", str_c[b+1] - str_c[b], 2);
        chk("t3_count", count, 13);
`endif

        // len=0 with start pulsed while busy
        b = str_a.size(); d0 = done_cnt;
        @(negedge clk);
        s = cyc;
        start = 1'b1; base = 8'h00; len = 9'd0;
        @(negedge clk);
        chk("t4_core_reset_set", core_reset, 1);
        chk("t4_busy", busy, 1);
        chk("t4_snoopp", bus.snoopp, 0);
        len = 9'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0);
        chk("t4_done_lat", done_cyc - s, 3);
        repeat (3) @(negedge clk);
        chk("t4_busy_end", busy, 0);
        chk("t4_nstrobes", str_a.size() - b, 0);
        chk("t4_count", count, 0);
        chk("t4_core_reset", core_reset, 0);

        // reset after the fifth word
        load_t1_words();
        b = str_a.size();
        start_load(8'h00, 9'd13, s);
        feed(5, 1'b0);
        chk("t5_fifth_strobe", bus.snoopw, 1);
        reset = 1'b0;
        #1;
        chk("t5_in_ready", bus.in_ready, 0);
        chk("t5_snoopw", bus.snoopw, 0);
        chk("t5_snoopp", bus.snoopp, 0);
        chk("t5_snoopm", bus.snoopm, 0);
        chk("t5_snoopa", bus.snoopa, 0);
        chk("t5_snoopd", bus.snoopd, 0);
        chk("t5_core_reset", core_reset, 1);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_error", error, 0);
        chk("t5_count", count, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t5_nstrobes", str_a.size() - b, 5);
        chk("t5_busy_after", busy, 0);

`ifdef SNOOP_LOADER_CSUM_EN
        // checksum match then mismatch
        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03; wbuf[3] = 8'h06;
        b = str_a.size(); d0 = done_cnt;
        start_load(8'h00, 9'd3, s);
        feed(4, 1'b0);
        wait_done(d0);
        chk("c1_nstrobes", str_a.size() - b, 3);
        chk("c1_error", error, 0);
        chk("c1_core_reset", core_reset, 0);
        wbuf[3] = 8'h07;
        d0 = done_cnt;
        start_load(8'h00, 9'd3, s);
        feed(4, 1'b0);
        repeat (8) @(negedge clk);
        chk("c2_no_done", done_cnt - d0, 0);
        chk("c2_error", error, 1);
        chk("c2_core_reset", core_reset, 1);
        chk("c2_busy", busy, 0);
`endif

        chk("snoopp_on_strobes", pp_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/snoop_loader.md
SNOOP_LOADER -- requirements
Module: snoop_loader

Interface
REQ-001 SHALL have parameter AW, default 8, snoop address width in bits.
REQ-002 SHALL have parameter DW, default 8, image word and snoop data width in bits.
REQ-003 SHALL have parameter RELEASE_CYC, default 2, number of cycles core_reset stays high after the last write (range 1..15).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-007 SHALL have port base  in  AW  first target address; captured when start is accepted.
REQ-008 SHALL have port len  in  AW+1  image word count, 0..2^AW; captured when start is accepted.
REQ-009 SHALL have port in_data  in  DW, in_valid  in  1, in_ready  out  1  image word stream; a word transfers when in_valid and in_ready are both high.
REQ-010 SHALL have port snoopa  out  AW, snoopd  out  DW, snoopw  out  1  registered snoop write address, data and one-cycle write strobe.
REQ-011 SHALL have port snoopp  out  1  snoop window; high for the whole load.
REQ-012 SHALL have port snoopm  out  1  snoop mode; constant 0 (write).
REQ-013 SHALL have port core_reset  out  1  active-high reset to the core.
REQ-014 SHALL have port busy  out  1, done  out  1, error  out  1, count  out  AW+1  status: done is a one-cycle pulse; count is words consumed.

Function
REQ-015 SHALL implement the states IDLE, LOAD, RELEASE and, with the Configuration macro defined, CHECK.
REQ-016 In IDLE, start=1 SHALL capture base and len, clear count and error, and enter LOAD; if len=0, it SHALL enter RELEASE directly.
REQ-017 In LOAD, in_ready SHALL be 1 and one word SHALL be accepted per cycle at most; in_valid low SHALL stall with no write.
REQ-018 An accepted non-zero word SHALL produce snoopw=1 in the following cycle, with snoopa=base+count (mod 2^AW) and snoopd=word.
REQ-019 An accepted zero word SHALL advance the address and count with snoopw=0 (zero-skip).
REQ-020 Address arithmetic SHALL wrap modulo 2^AW; len=2^AW SHALL write every address exactly once.
REQ-021 After the len-th word is accepted, the block SHALL leave LOAD and deassert in_ready in the next cycle; the final write strobe SHALL still be issued.
REQ-022 In RELEASE, snoopp SHALL be 0, core_reset SHALL stay 1 for RELEASE_CYC cycles, then core_reset SHALL drop to 0, done SHALL pulse, and the block SHALL return to IDLE.
REQ-023 snoopp SHALL be 1 exactly in LOAD and CHECK and for the cycle carrying the last write strobe.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 start while busy=1 SHALL be ignored without any state change.
REQ-026 core_reset SHALL be 1 from reset until the first successful done, and SHALL return to 1 when a new load starts.

Reset
REQ-027 Reset low SHALL force IDLE asynchronously: in_ready=0, snoopw=0, snoopp=0, snoopm=0, snoopa=0, snoopd=0, core_reset=1, busy=0, done=0, error=0, count=0.
REQ-028 Reset mid-LOAD SHALL abort the load with no further strobes; memory contents are undefined and a new start is required.

Configuration
REQ-029 With SNOOP_LOADER_CSUM_EN defined, the block SHALL keep a DW-bit modulo-2^DW sum of all accepted image words, including zeros, and after the len-th word SHALL enter CHECK and accept exactly one more word as the expected sum.
REQ-030 In CHECK, on a match the block SHALL enter RELEASE; on a mismatch it SHALL set error=1, keep core_reset=1, skip the done pulse, and return to IDLE.
REQ-031 Without SNOOP_LOADER_CSUM_EN, there SHALL be no CHECK state and no checksum logic, and error SHALL be tied to 0.

Verification
REQ-032 base=0, len=13, stream 98,0C,14,03,92,E8,0C,18,82,92,92,82,60 with in_valid always high -> 13 strobes at addresses 0..12 with matching data; core_reset falls 2 cycles after the last strobe; done pulses once.
REQ-033 base=FE, len=4, stream 11,00,22,33 -> strobes at addresses FE, 00, 01 only, and no strobe at FF; count=4.
REQ-034 in_valid toggling every other cycle during REQ-032 -> same writes with no duplicates and the stall visible on snoopw.
REQ-035 len=0 -> no strobes; done pulses RELEASE_CYC+1 cycles after start; start pulsed while busy is ignored.
REQ-036 Reset driven low after the 5th word -> outputs match REQ-027 immediately, with no further strobes.
REQ-037 With CSUM_EN, stream 01,02,03 followed by check word 06 -> done; check word 07 -> error=1, core_reset stays 1, no done.
